rd_req_tagger: RTL
==================

// Module: rd_req_tagger
// PURPOSE
//  Read-request intake stage upstream of the reorder buffer. Accepts single-beat AXI AR requests,
//  stamps each with a sequential transaction ID (tID), records ARID per tID, forwards the tagged
//  request to tag-compare. Limits in-flight tIDs so none is reused before the ROB retires it, and
//  returns the original ARID to the ROB for the R channel.
// PARAMETERS
//  ADDR_WIDTH       `AXI_ADDR_WIDTH   request address width
//  ID_WIDTH         `AXI_ID_WIDTH     AXI ARID/RID width
//  TID_WIDTH        `TID_WIDTH        transaction-ID width; tIDs wrap mod 2**TID_WIDTH
//  MAX_OUTSTANDING  2**TID_WIDTH-1    max tIDs in flight; legal range 1..2**TID_WIDTH-1
// PORTS
//  clk            in   1           clock
//  rst_n          in   1           synchronous active-low reset
//  arvalid_i      in   1           AXI AR valid
//  arready_o      out  1           AXI AR ready
//  arid_i         in   ID_WIDTH    AXI ARID
//  araddr_i       in   ADDR_WIDTH  AXI ARADDR
//  req_valid_o    out  1           tagged request valid to tag-compare
//  req_ready_i    in   1           tag-compare ready
//  req_tid_o      out  TID_WIDTH   assigned tID
//  req_addr_o     out  ADDR_WIDTH  request address
//  retire_i       in   1           ROB R-beat handshake (valid & ready), one per tID
//  retire_tid_i   in   TID_WIDTH   tID being retired
//  lookup_tid_i   in   TID_WIDTH   ROB query tID
//  lookup_id_o    out  ID_WIDTH    ARID stored for lookup_tid_i (combinational)
//  outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  in-flight count
//  err_o          out  1           sticky protocol error
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): next_tid=1, outstanding=0, req_valid_o=0, req_tid_o=0,
//   req_addr_o=0, err_o=0, ID table cleared to 0; arready_o=0 while rst_n=0.
//  Credit: can_accept = outstanding < MAX_OUTSTANDING.
//  Output stage: one registered slot. arready_o = rst_n & can_accept & (!req_valid_o | req_ready_i).
//   Comb path from req_ready_i to arready_o is intended (full throughput, 1 req/cycle).
//  AR handshake (arvalid_i & arready_o): next cycle req_valid_o=1, req_tid_o=next_tid,
//   req_addr_o=araddr_i; table[next_tid]<=arid_i; next_tid<=next_tid+1 (wraps 2**TID_WIDTH-1 -> 0);
//   outstanding+1. Latency AR accept -> req_valid_o: 1 cycle.
//  Downstream: req_valid_o held with stable tid/addr until req_ready_i; clears on handshake
//   unless a new AR is accepted same cycle (then reloads). req_valid_o never depends on req_ready_i.
//  Retire: retire_i decrements outstanding. Same-cycle accept+retire: outstanding unchanged.
//   retire_i with outstanding==0: counter holds at 0, err_o<=1.
//   retire_tid_i != oldest in-flight tID (next_tid-outstanding mod 2**TID_WIDTH): err_o<=1,
//   retire still counted. err_o clears only on reset.
//  Lookup: lookup_id_o = table[lookup_tid_i], async read; write in same cycle visible next cycle.
//  Full: outstanding==MAX_OUTSTANDING -> arready_o=0 until a retire; a retire in cycle N permits
//   accept in cycle N+1 (credit is registered).
//  Reset mid-operation: pending output slot and all in-flight state discarded; tIDs restart at 1.
// STRUCTURE
//  Shared package dram_cache_pkg: tid_t (logic [TID_WIDTH-1:0]), TID_FIRST=1, tagged-request struct
//   {tid, addr} reused by tag-compare.
//  Sub-module tid_id_table: 2**TID_WIDTH x ID_WIDTH register file, 1 sync write, 1 async read, sync clear.
//  Top holds tID counter, credit counter, output register, error checker.
// TESTING
//  1. Reset, 3 back-to-back ARs (id 5,6,7), req_ready_i=1 -> req_tid 1,2,3 on consecutive cycles,
//     outstanding=3, lookup_tid=2 -> lookup_id=6.
//  2. MAX_OUTSTANDING=4, 5 ARs, no retires -> arready_o=0 after 4th; retire tid 1 -> 5th accepted
//     next cycle with tid 5.
//  3. req_ready_i=0 for 4 cycles with req_valid_o=1 -> tid/addr stable, arready_o=0; release ->
//     handshake, next AR accepted same cycle.
//  4. TID_WIDTH=3: issue/retire 9 requests in order -> tids 1..7,0,1; err_o stays 0.
//  5. Same-cycle AR accept and retire at outstanding=2 -> outstanding stays 2.
//  6. retire_i at outstanding=0, and out-of-order retire_tid -> err_o=1, sticky until rst_n.

Source files
------------

// File: rtl/dram_cache_pkg.sv
// Shared types and defaults for the DRAM-cache read path (intake, tag-compare, ROB).
package dram_cache_pkg;

    localparam int AXI_ADDR_WIDTH_DEF = 32;
    localparam int AXI_ID_WIDTH_DEF   = 4;
    localparam int TID_WIDTH_DEF      = 4;

    // tIDs start at 1 after reset so that 0 first appears only after a full wrap.
    localparam int TID_FIRST = 1;

    typedef logic [TID_WIDTH_DEF-1:0] tid_t;

    typedef struct packed {
        tid_t                          tid;
        logic [AXI_ADDR_WIDTH_DEF-1:0] addr;
    } tagged_req_t;

endpackage

// File: rtl/rd_req_tagger_tid_id_table.sv
// Per-tID ARID store: one synchronous write port, one asynchronous read port, synchronous clear.
module tid_id_table
    import dram_cache_pkg::*;
#(
    parameter int ID_WIDTH  = AXI_ID_WIDTH_DEF,
    parameter int TID_WIDTH = TID_WIDTH_DEF
)(
    input  logic                 clk,
    input  logic                 clr_i,
    input  logic                 wr_en_i,
    input  logic [TID_WIDTH-1:0] wr_tid_i,
    input  logic [ID_WIDTH-1:0]  wr_id_i,
    input  logic [TID_WIDTH-1:0] rd_tid_i,
    output logic [ID_WIDTH-1:0]  rd_id_o
);

    localparam int DEPTH = 1 << TID_WIDTH;

    logic [DEPTH-1:0][ID_WIDTH-1:0] rd_bus;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
        logic [ID_WIDTH-1:0] entry_d;
        logic [ID_WIDTH-1:0] entry_q;

        always_comb begin
            entry_d = entry_q;
            if (wr_en_i && (wr_tid_i == TID_WIDTH'(gi))) begin
                entry_d = wr_id_i;
            end
        end

        always_ff @(posedge clk) begin
            if (clr_i) begin
                entry_q <= '0;
            end else begin
                entry_q <= entry_d;
            end
        end

        assign rd_bus[gi] = entry_q;
    end

    assign rd_id_o = rd_bus[rd_tid_i];

endmodule

// File: rtl/rd_req_tagger.sv
// AR intake: stamps sequential tIDs, limits tIDs in flight, records ARID per tID for the ROB.
module rd_req_tagger
    import dram_cache_pkg::*;
#(
    parameter int ADDR_WIDTH      = AXI_ADDR_WIDTH_DEF,
    parameter int ID_WIDTH        = AXI_ID_WIDTH_DEF,
    parameter int TID_WIDTH       = TID_WIDTH_DEF,
    parameter int MAX_OUTSTANDING = (1 << TID_WIDTH) - 1,
    localparam int CNT_WIDTH      = $clog2(MAX_OUTSTANDING + 1)
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    input  logic [ID_WIDTH-1:0]   arid_i,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic [TID_WIDTH-1:0]  req_tid_o,
    output logic [ADDR_WIDTH-1:0] req_addr_o,
    input  logic                  retire_i,
    input  logic [TID_WIDTH-1:0]  retire_tid_i,
    input  logic [TID_WIDTH-1:0]  lookup_tid_i,
    output logic [ID_WIDTH-1:0]   lookup_id_o,
    output logic [CNT_WIDTH-1:0]  outstanding_o,
    output logic                  err_o
);

    logic [TID_WIDTH-1:0]  next_tid_q, next_tid_d;
    logic [CNT_WIDTH-1:0]  outstanding_q, outstanding_d;
    logic                  req_valid_q, req_valid_d;
    logic [TID_WIDTH-1:0]  req_tid_q, req_tid_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                  err_q, err_d;

    logic                  can_accept;
    logic                  ar_fire;
    logic [TID_WIDTH-1:0]  oldest_tid;

    // Credit comes from the registered count, so a retire frees a slot one cycle later.
    assign can_accept = outstanding_q < CNT_WIDTH'(MAX_OUTSTANDING);
    assign arready_o  = rst_n & can_accept & (~req_valid_q | req_ready_i);
    assign ar_fire    = arvalid_i & arready_o;
    assign oldest_tid = next_tid_q - TID_WIDTH'(outstanding_q);

    always_comb begin
        next_tid_d    = next_tid_q;
        outstanding_d = outstanding_q;
        req_valid_d   = req_valid_q;
        req_tid_d     = req_tid_q;
        req_addr_d    = req_addr_q;
        err_d         = err_q;

        if (ar_fire) begin
            req_valid_d = 1'b1;
            req_tid_d   = next_tid_q;
            req_addr_d  = araddr_i;
            next_tid_d  = next_tid_q + TID_WIDTH'(1);
        end else if (req_valid_q && req_ready_i) begin
            req_valid_d = 1'b0;
        end

        if (retire_i && ((outstanding_q == '0) || (retire_tid_i != oldest_tid))) begin
            err_d = 1'b1;
        end

        // A retire with nothing in flight is ignored by the counter.
        unique case ({ar_fire, retire_i})
            2'b10: outstanding_d = outstanding_q + CNT_WIDTH'(1);
            2'b01: if (outstanding_q != '0) outstanding_d = outstanding_q - CNT_WIDTH'(1);
            2'b11: if (outstanding_q == '0) outstanding_d = CNT_WIDTH'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            next_tid_q    <= TID_WIDTH'(TID_FIRST);
            outstanding_q <= '0;
            req_valid_q   <= 1'b0;
            req_tid_q     <= '0;
            req_addr_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            next_tid_q    <= next_tid_d;
            outstanding_q <= outstanding_d;
            req_valid_q   <= req_valid_d;
            req_tid_q     <= req_tid_d;
            req_addr_q    <= req_addr_d;
            err_q         <= err_d;
        end
    end

    tid_id_table #(
        .ID_WIDTH  (ID_WIDTH),
        .TID_WIDTH (TID_WIDTH)
    ) u_tid_id_table (
        .clk      (clk),
        .clr_i    (~rst_n),
        .wr_en_i  (ar_fire),
        .wr_tid_i (next_tid_q),
        .wr_id_i  (arid_i),
        .rd_tid_i (lookup_tid_i),
        .rd_id_o  (lookup_id_o)
    );

    assign req_valid_o   = req_valid_q;
    assign req_tid_o     = req_tid_q;
    assign req_addr_o    = req_addr_q;
    assign outstanding_o = outstanding_q;
    assign err_o         = err_q;

endmodule
